id_ex_ctrl_pipe: RTL and testbench
==================================

ID_EX_CTRL_PIPE -- requirements
Module: id_ex_ctrl_pipe

Interface
REQ-001 Parameters: EX_W, 2, EX control width (ALUOp); MEM_W, 2, MEM control width; WB_W, 2, WB control width.
REQ-002 Parameters: REG_AW, 5, register-address width; MEMREAD_BIT, 0, index of MemRead within mem_ctrl; FLUSH_CYCLES, 1, bubbles per taken branch (1..7); CNT_W, 16, perf counter width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 ex_ctrl_in / mem_ctrl_in / wb_ctrl_in  in  EX_W / MEM_W / WB_W  decoded control from ID.
REQ-006 id_valid  in  1  ID holds a real instruction.
REQ-007 id_rs, id_rt  in  REG_AW  source registers of ID instruction.
REQ-008 branch_taken  in  1  branch resolved taken this cycle (branch & zero).
REQ-009 ext_stall  in  1  downstream memory wait; freeze pipeline.
REQ-010 ex_ctrl_q / mem_ctrl_q / wb_ctrl_q  out  EX_W / MEM_W / WB_W  registered ID/EX control.
REQ-011 ex_rt_q  out  REG_AW  registered rt of instruction now in EX.
REQ-012 pc_write, ifid_write  out  1  combinational PC / IF-ID enable.
REQ-013 ifid_flush  out  1  combinational IF/ID squash.
REQ-014 bubble_q  out  1  registered: EX holds an inserted bubble.
REQ-015 state_q  out  2  FSM state (RUN=0, FLUSH=1, HOLD=2).

Function
REQ-016 Event priority per cycle SHALL be: ext_stall > branch_taken/FLUSH > load-use > normal.
REQ-017 Load-use hazard SHALL be mem_ctrl_q[MEMREAD_BIT] & ex_rt_q!=0 & id_valid & (ex_rt_q==id_rs | ex_rt_q==id_rt).
REQ-018 Normal (RUN, no event): next edge loads *_ctrl_in, id_rt into ID/EX; bubble_q<=0; pc_write=ifid_write=1, ifid_flush=0.
REQ-019 Load-use in RUN: pc_write=ifid_write=0 same cycle; next edge loads all-zero control, bubble_q<=1; exactly one bubble, state stays RUN.
REQ-020 branch_taken in RUN: ifid_flush=1, pc_write=1 same cycle; next edge loads zero control, bubble_q<=1; if FLUSH_CYCLES>1 enter FLUSH with counter=FLUSH_CYCLES-1, else stay RUN.
REQ-021 FLUSH: each cycle ifid_flush=1, zero control loaded, counter decrements; at counter==1 return to RUN; load-use ignored in FLUSH.
REQ-022 ext_stall in any state: enter/stay HOLD; ID/EX registers, bubble_q and flush counter unchanged; pc_write=ifid_write=0, ifid_flush=0; branch_taken ignored.
REQ-023 ext_stall deasserted in HOLD: return to state held on entry (RUN or FLUSH) next edge, resuming counter.
REQ-024 id_valid=0 in RUN: zero control loaded, bubble_q<=0 (not counted as inserted bubble).
REQ-025 Unused state encoding 3 SHALL recover to RUN next edge.

Reset
REQ-026 rst_n low SHALL immediately clear all *_q outputs, ex_rt_q, flush counter, and set state_q=RUN, independent of clk.
REQ-027 Reset mid-FLUSH or mid-HOLD SHALL abandon the operation; first post-reset cycle behaves as RUN with empty EX.

Configuration
REQ-028 Macro ID_EX_PERF_CNT_EN defined: add output bubble_cnt (CNT_W), incremented on every edge where bubble_q becomes 1, saturating at all-ones, cleared by reset.
REQ-029 Macro undefined: bubble_cnt port and counter absent; all other behaviour identical.

Structure
REQ-030 Package pipe_ctrl_pkg SHALL hold state enum (RUN/FLUSH/HOLD) and default width constants.
REQ-031 Sub-module hazard_detect SHALL implement REQ-017 combinationally; FSM and registers stay in id_ex_ctrl_pipe.

Verification
REQ-032 Reset: rst_n=0 mid-cycle -> all outputs 0, state_q=0 without clock edge.
REQ-033 Load-use: EX holds lw rt=5 (mem_ctrl_q[0]=1), ID id_rs=5 -> pc_write=0 one cycle, then bubble_q=1, ctrl_q=0, then ID instruction enters EX.
REQ-034 rt=0 case: EX lw rt=0, id_rs=0 -> no stall, pc_write=1.
REQ-035 Branch with FLUSH_CYCLES=3: branch_taken 1 cycle -> ifid_flush high 3 consecutive cycles, 3 bubbles, state 0->1->1->0.
REQ-036 ext_stall 4 cycles during FLUSH (counter=2) -> outputs frozen, state_q=2; release -> 2 more flush cycles.
REQ-037 With ID_EX_PERF_CNT_EN, CNT_W=4: 17 bubbles -> bubble_cnt=15 (saturated).

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: state encoding and default widths for the ID/EX control pipe
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN = 2'd0, FLUSH = 2'd1, HOLD = 2'd2} state_t;
    localparam int DEF_EX_W = 2;
    localparam int DEF_MEM_W = 2;
    localparam int DEF_WB_W = 2;
    localparam int DEF_REG_AW = 5;
    localparam int DEF_CNT_W = 16;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the load in EX and the instruction in ID
module hazard_detect #(
    parameter int REG_AW = 5
) (
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    output logic              hazard
);
    // r0 is never a real dependency, so a load into it never stalls
    assign hazard = ex_memread & (|ex_rt) & id_valid & ((ex_rt == id_rs) | (ex_rt == id_rt));
endmodule

// File: rtl/id_ex_ctrl_pipe.sv
// id_ex_ctrl_pipe: ID/EX control register with load-use stall, branch flush and external hold (bubble counter when ID_EX_PERF_CNT_EN is defined)
module id_ex_ctrl_pipe
    import pipe_ctrl_pkg::*;
#(
    parameter int EX_W = DEF_EX_W,
    parameter int MEM_W = DEF_MEM_W,
    parameter int WB_W = DEF_WB_W,
    parameter int REG_AW = DEF_REG_AW,
    parameter int MEMREAD_BIT = 0,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [EX_W-1:0]   ex_ctrl_in,
    input  logic [MEM_W-1:0]  mem_ctrl_in,
    input  logic [WB_W-1:0]   wb_ctrl_in,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              branch_taken,
    input  logic              ext_stall,
    output logic [EX_W-1:0]   ex_ctrl_q,
    output logic [MEM_W-1:0]  mem_ctrl_q,
    output logic [WB_W-1:0]   wb_ctrl_q,
    output logic [REG_AW-1:0] ex_rt_q,
    output logic              pc_write,
    output logic              ifid_write,
    output logic              ifid_flush,
    output logic              bubble_q,
`ifdef ID_EX_PERF_CNT_EN
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output state_t            state_q
);
    state_t ret_q;
    logic [2:0] cnt_q;
    logic hz, frz, run, fl, lu, bub, ld;

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .ex_memread(mem_ctrl_q[MEMREAD_BIT]),
        .ex_rt(ex_rt_q),
        .id_valid(id_valid),
        .id_rs(id_rs),
        .id_rt(id_rt),
        .hazard(hz)
    );

    // front-end enables and bubble decision; a branch outranks load-use, a stall outranks both
    always_comb begin
        run = state_q == RUN;
        fl = state_q == FLUSH;
        frz = ext_stall | (state_q == HOLD);
        lu = ~frz & run & ~branch_taken & hz;
        ifid_flush = ~frz & (fl | (run & branch_taken));
        pc_write = ~frz & (run | fl) & ~lu;
        ifid_write = pc_write;
        bub = ifid_flush | lu;
        ld = ~frz & run & ~bub & id_valid;
    end

    // ID/EX control register; frozen while stalled, zeroed for bubbles and empty slots
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_ctrl_q <= '0;
            mem_ctrl_q <= '0;
            wb_ctrl_q <= '0;
            ex_rt_q <= '0;
            bubble_q <= 1'b0;
        end else if (!frz) begin
            ex_ctrl_q <= ld ? ex_ctrl_in : '0;
            mem_ctrl_q <= ld ? mem_ctrl_in : '0;
            wb_ctrl_q <= ld ? wb_ctrl_in : '0;
            ex_rt_q <= ld ? id_rt : '0;
            bubble_q <= bub;
        end
    end

    // control FSM; HOLD remembers where to resume and leaves the flush counter alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            ret_q <= RUN;
            cnt_q <= '0;
        end else if (ext_stall) begin
            state_q <= HOLD;
            if (state_q != HOLD) ret_q <= fl ? FLUSH : RUN;
        end else begin
            case (state_q)
                RUN: if (branch_taken && FLUSH_CYCLES > 1) begin
                    state_q <= FLUSH;
                    cnt_q <= 3'(FLUSH_CYCLES - 1);
                end
                FLUSH: begin
                    cnt_q <= cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) state_q <= RUN;
                end
                HOLD: state_q <= ret_q;
                default: state_q <= RUN;
            endcase
        end
    end

`ifdef ID_EX_PERF_CNT_EN
    // count every bubble written into EX, saturating at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bubble_cnt <= '0;
        else if (!frz && bub && !(&bubble_cnt)) bubble_cnt <= bubble_cnt + CNT_W'(1);
    end
`else
    logic [CNT_W-1:0] unused_cnt_w;
    assign unused_cnt_w = '0;
`endif
endmodule

// File: tb/tb_id_ex_ctrl_pipe.sv
// tb_id_ex_ctrl_pipe: directed scenarios plus randomized run against a behavioural model
module tb_id_ex_ctrl_pipe;
    localparam int FC = 3;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic clk = 1'b0, rst_n = 1'b0;
    logic [1:0] ex_ctrl_in = '0, mem_ctrl_in = '0, wb_ctrl_in = '0;
    logic id_valid = 1'b0, branch_taken = 1'b0, ext_stall = 1'b0;
    logic [4:0] id_rs = '0, id_rt = '0;
    logic [1:0] ex_ctrl_q, mem_ctrl_q, wb_ctrl_q, state_q;
    logic [4:0] ex_rt_q;
    logic pc_write, ifid_write, ifid_flush, bubble_q;
`ifdef ID_EX_PERF_CNT_EN
    logic [CW-1:0] bubble_cnt;
`endif

    int checks = 0, failures = 0;

    // behavioural model: EX contents, remaining flush slots, hold flag, bubble tally
    logic [5:0] m_ctrl;
    logic [4:0] m_rt;
    logic m_rtk, m_bub, m_hold, e_pc, e_flush, e_lu;
    int m_rem, m_cnt;

    id_ex_ctrl_pipe #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_ctrl_in(ex_ctrl_in), .mem_ctrl_in(mem_ctrl_in), .wb_ctrl_in(wb_ctrl_in),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .branch_taken(branch_taken), .ext_stall(ext_stall),
        .ex_ctrl_q(ex_ctrl_q), .mem_ctrl_q(mem_ctrl_q), .wb_ctrl_q(wb_ctrl_q),
        .ex_rt_q(ex_rt_q), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .bubble_q(bubble_q),
`ifdef ID_EX_PERF_CNT_EN
        .bubble_cnt(bubble_cnt),
`endif
        .state_q(state_q)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset;
        m_ctrl = '0;
        m_rt = '0;
        m_rtk = 1'b0;
        m_bub = 1'b0;
        m_hold = 1'b0;
        m_rem = 0;
        m_cnt = 0;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        {ex_ctrl_in, mem_ctrl_in, wb_ctrl_in, id_valid, branch_taken, ext_stall, id_rs, id_rt} = '0;
        #2;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic model_comb;
        logic frozen, hz;
        frozen = ext_stall || m_hold;
        hz = m_ctrl[2] && m_rt != 0 && id_valid && (m_rt == id_rs || m_rt == id_rt);
        e_flush = !frozen && (m_rem > 0 || branch_taken);
        e_lu = !frozen && m_rem == 0 && !branch_taken && hz;
        e_pc = !frozen && !e_lu;
    endtask

    task automatic model_edge;
        if (ext_stall) m_hold = 1'b1;
        else if (m_hold) m_hold = 1'b0;
        else if (e_flush || e_lu) begin
            m_ctrl = '0;
            m_rt = '0;
            m_rtk = 1'b0;
            m_bub = 1'b1;
            if (e_flush) m_rem = m_rem > 0 ? m_rem - 1 : FC - 1;
            if (m_cnt < CMAX) m_cnt++;
        end else begin
            m_ctrl = id_valid ? {ex_ctrl_in, mem_ctrl_in, wb_ctrl_in} : '0;
            m_rt = id_valid ? id_rt : '0;
            m_rtk = id_valid;
            m_bub = 1'b0;
        end
    endtask

    task automatic test_reset;
        apply_reset();
        id_valid = 1'b1;
        {ex_ctrl_in, mem_ctrl_in, wb_ctrl_in} = 6'b111111;
        id_rt = 5'd9;
        tick();
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ex_ctrl_q, mem_ctrl_q, wb_ctrl_q, ex_rt_q, bubble_q, state_q} !== '0) begin
            failures++;
            $display("FAIL reset_async: got ctrl=%b rt=%0d bub=%b st=%0d want all 0", {ex_ctrl_q, mem_ctrl_q, wb_ctrl_q}, ex_rt_q, bubble_q, state_q);
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (bubble_cnt !== '0) begin
            failures++;
            $display("FAIL reset_cnt: got %0d want 0", bubble_cnt);
        end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_load_use;
        apply_reset();
        id_valid = 1'b1;
        {ex_ctrl_in, mem_ctrl_in, wb_ctrl_in} = 6'b10_01_11;
        id_rs = 5'd1;
        id_rt = 5'd5;
        tick();
        {ex_ctrl_in, mem_ctrl_in, wb_ctrl_in} = 6'b11_10_01;
        id_rs = 5'd5;
        id_rt = 5'd7;
        #1;
        checks++;
        if (pc_write !== 1'b0 || ifid_write !== 1'b0) begin
            failures++;
            $display("FAIL lu_stall: got pc_write=%b ifid_write=%b want 0 0", pc_write, ifid_write);
        end
        tick();
        checks++;
        if (bubble_q !== 1'b1 || {ex_ctrl_q, mem_ctrl_q, wb_ctrl_q} !== 6'b0) begin
            failures++;
            $display("FAIL lu_bubble: got bub=%b ctrl=%b want 1 000000", bubble_q, {ex_ctrl_q, mem_ctrl_q, wb_ctrl_q});
        end
        checks++;
        if (pc_write !== 1'b1) begin
            failures++;
            $display("FAIL lu_release: got pc_write=%b want 1", pc_write);
        end
        tick();
        checks++;
        if ({ex_ctrl_q, mem_ctrl_q, wb_ctrl_q} !== 6'b11_10_01 || ex_rt_q !== 5'd7 || bubble_q !== 1'b0) begin
            failures++;
            $display("FAIL lu_enter: got ctrl=%b rt=%0d bub=%b want 111001 7 0", {ex_ctrl_q, mem_ctrl_q, wb_ctrl_q}, ex_rt_q, bubble_q);
        end
    endtask

    task automatic test_rt0;
        apply_reset();
        id_valid = 1'b1;
        {ex_ctrl_in, mem_ctrl_in, wb_ctrl_in} = 6'b00_01_11;
        id_rt = 5'd0;
        tick();
        id_rs = 5'd0;
        #1;
        checks++;
        if (pc_write !== 1'b1 || mem_ctrl_q[0] !== 1'b1) begin
            failures++;
            $display("FAIL rt0_nostall: got pc_write=%b memread=%b want 1 1", pc_write, mem_ctrl_q[0]);
        end
        tick();
        checks++;
        if (bubble_q !== 1'b0) begin
            failures++;
            $display("FAIL rt0_nobubble: got %b want 0", bubble_q);
        end
    endtask

    task automatic test_branch;
        logic [1:0] st [3] = '{2'd1, 2'd1, 2'd0};
        apply_reset();
        id_valid = 1'b1;
        {ex_ctrl_in, mem_ctrl_in, wb_ctrl_in} = 6'b10_10_10;
        branch_taken = 1'b1;
        #1;
        checks++;
        if (ifid_flush !== 1'b1 || pc_write !== 1'b1 || state_q !== 2'd0) begin
            failures++;
            $display("FAIL br_first: got flush=%b pc=%b st=%0d want 1 1 0", ifid_flush, pc_write, state_q);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            branch_taken = 1'b0;
            #1;
            checks++;
            if (state_q !== st[i] || bubble_q !== 1'b1 || ex_ctrl_q !== 2'b0 || ifid_flush !== (i < 2)) begin
                failures++;
                $display("FAIL br_seq%0d: got st=%0d bub=%b ex=%b flush=%b want %0d 1 0 %0d", i, state_q, bubble_q, ex_ctrl_q, ifid_flush, st[i], i < 2);
            end
        end
    endtask

    task automatic test_stall_flush;
        int nfl;
        apply_reset();
        id_valid = 1'b1;
        branch_taken = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            ext_stall = 1'b1;
            {ex_ctrl_in, mem_ctrl_in, wb_ctrl_in} = 6'($urandom);
            #1;
            checks++;
            if (pc_write !== 1'b0 || ifid_write !== 1'b0 || ifid_flush !== 1'b0) begin
                failures++;
                $display("FAIL stall_comb%0d: got pc=%b ifw=%b flush=%b want 0 0 0", i, pc_write, ifid_write, ifid_flush);
            end
            tick();
            checks++;
            if (state_q !== 2'd2 || bubble_q !== 1'b1 || {ex_ctrl_q, mem_ctrl_q, wb_ctrl_q} !== 6'b0) begin
                failures++;
                $display("FAIL stall_frozen%0d: got st=%0d bub=%b ctrl=%b want 2 1 000000", i, state_q, bubble_q, {ex_ctrl_q, mem_ctrl_q, wb_ctrl_q});
            end
        end
        ext_stall = 1'b0;
        branch_taken = 1'b0;
        nfl = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            nfl += int'(ifid_flush);
            tick();
        end
        checks++;
        if (nfl != 2 || state_q !== 2'd0) begin
            failures++;
            $display("FAIL stall_resume: got flushes=%0d st=%0d want 2 0", nfl, state_q);
        end
    endtask

    task automatic test_reset_mid;
        apply_reset();
        id_valid = 1'b1;
        branch_taken = 1'b1;
        tick();
        branch_taken = 1'b0;
        {ex_ctrl_in, mem_ctrl_in, wb_ctrl_in} = 6'b01_00_10;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state_q !== 2'd0 || bubble_q !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_async: got st=%0d bub=%b want 0 0", state_q, bubble_q);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (ifid_flush !== 1'b0 || pc_write !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_run: got flush=%b pc=%b want 0 1", ifid_flush, pc_write);
        end
        tick();
        checks++;
        if ({ex_ctrl_q, mem_ctrl_q, wb_ctrl_q} !== 6'b01_00_10 || bubble_q !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_load: got ctrl=%b bub=%b want 010010 0", {ex_ctrl_q, mem_ctrl_q, wb_ctrl_q}, bubble_q);
        end
    endtask

`ifdef ID_EX_PERF_CNT_EN
    task automatic test_perf;
        apply_reset();
        id_valid = 1'b1;
        for (int b = 0; b < 6; b++) begin
            branch_taken = 1'b1;
            tick();
            branch_taken = 1'b0;
            tick();
            tick();
            if (b == 3) begin
                checks++;
                if (bubble_cnt !== CW'(12)) begin
                    failures++;
                    $display("FAIL perf_count: got %0d want 12", bubble_cnt);
                end
            end
        end
        checks++;
        if (bubble_cnt !== CW'(CMAX)) begin
            failures++;
            $display("FAIL perf_sat: got %0d want %0d", bubble_cnt, CMAX);
        end
    endtask
`endif

    task automatic test_random;
        apply_reset();
        for (int c = 0; c < 600; c++) begin
            ext_stall = $urandom_range(0, 5) == 0;
            branch_taken = $urandom_range(0, 7) == 0;
            id_valid = $urandom_range(0, 7) != 0;
            id_rs = 5'($urandom_range(0, 3));
            id_rt = 5'($urandom_range(0, 3));
            {ex_ctrl_in, mem_ctrl_in, wb_ctrl_in} = 6'($urandom);
            #1;
            model_comb();
            checks++;
            if (pc_write !== e_pc || ifid_write !== e_pc || ifid_flush !== e_flush) begin
                failures++;
                $display("FAIL rnd_comb c=%0d: got pc=%b ifw=%b flush=%b want %b %b %b", c, pc_write, ifid_write, ifid_flush, e_pc, e_pc, e_flush);
            end
            model_edge();
            tick();
            checks++;
            if ({ex_ctrl_q, mem_ctrl_q, wb_ctrl_q} !== m_ctrl || bubble_q !== m_bub ||
                state_q !== (m_hold ? 2'd2 : (m_rem > 0 ? 2'd1 : 2'd0)) || (m_rtk && ex_rt_q !== m_rt)) begin
                failures++;
                $display("FAIL rnd_reg c=%0d: got ctrl=%b bub=%b st=%0d rt=%0d want %b %b hold=%b rem=%0d rt=%0d", c, {ex_ctrl_q, mem_ctrl_q, wb_ctrl_q}, bubble_q, state_q, ex_rt_q, m_ctrl, m_bub, m_hold, m_rem, m_rt);
            end
        end
`ifdef ID_EX_PERF_CNT_EN
        checks++;
        if (bubble_cnt !== CW'(m_cnt)) begin
            failures++;
            $display("FAIL rnd_cnt: got %0d want %0d", bubble_cnt, m_cnt);
        end
`endif
    endtask

    initial begin
        #3;
        test_reset();
        test_load_use();
        test_rt0();
        test_branch();
        test_stall_flush();
        test_reset_mid();
`ifdef ID_EX_PERF_CNT_EN
        test_perf();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
